obs_even_odd_mul_seq: RTL and testbench
=======================================

Name: obs_even_odd_mul_seq

Overview:
- Sequential carry-less (GF(2)[x]) multiplier for N-bit operands, using even/odd (OBS) decomposition.
- Each operand splits by coefficient parity: a(x) = ae(x^2) + x·ao(x^2).
- One shared H×H carry-less sub-multiplier is time-multiplexed over four cycles: ae·be, ae·bo, ao·be, ao·bo.
- Each sub-product is XORed into an interleaved 2N-1-bit accumulator using the overlap-stage bit mapping.
- Intended as the sequenced, area-reduced level of the OBS multiplier hierarchy.

Parameters:
- N, 26, operand width; must be even.
- H, N/2, half width (derived, not overridable); sub-product width is 2H-1.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  operands valid
- in_ready  out  1  block can accept operands
- a_in  in  N  operand A; bit i = coefficient of x^i
- b_in  in  N  operand B
- out_valid  out  1  product valid
- out_ready  in  1  consumer accepts product
- p_out  out  2N-1  product A·B over GF(2)
- busy  out  1  high while in MUL state

Behaviour:
- Reset (async, immediate): state=IDLE, step=0, acc=0, operand regs=0, out_valid=0, busy=0, in_ready=1 (combinational from IDLE).
- Reset mid-operation aborts the computation with no output; state returns to IDLE.
- States and transitions:
  - IDLE: in_ready=1. On edge with in_valid=1: latch ae/ao/be/bo, acc←0, step←0, go to MUL.
  - MUL: in_ready=0, busy=1. Each edge forms P = sel_a ⊗ sel_b (carry-less H×H, 2H-1 bits), XORs P into acc, then step←step+1. After the step=3 edge: go to DONE, out_valid←1, step←0.
  - DONE: out_valid=1, p_out=acc held stable. On edge with out_ready=1: out_valid←0, go to IDLE.
  - in_valid is ignored outside IDLE; operands need not remain stable after acceptance.
- Step schedule (two-bit step counter, wraps 3→0):
  - step 0: ae·be, into even positions: acc[2i] ^= P[i].
  - step 1: ae·bo, into odd positions: acc[2i+1] ^= P[i].
  - step 2: ao·be, into odd positions: acc[2i+1] ^= P[i].
  - step 3: ao·bo, into even positions shifted: acc[2i+2] ^= P[i].
  - Index range: i = 0..2H-2 in every step.
- Resulting bit mapping: acc[0]=P0[0]; acc[2N-2]=P3[2H-2]; the last odd bit acc[2N-3] is P1[2H-2]^P2[2H-2].
- Sub-multiplier: pure combinational AND/XOR array, P[k] = XOR over j of sa[j]&sb[k-j].
- Timing:
  - Latency is 4 edges from the accepting edge to out_valid=1.
  - Minimum issue interval is 6 cycles: accept, 4×MUL, DONE with out_ready=1.
  - In DONE with out_ready=1, the handshake completes on that edge. in_ready is not asserted in the same cycle; there is no overlap.
  - out_valid is never deasserted without out_ready.
  - p_out is 0 after reset. Between operations it holds the last result.
- Widths: no carries anywhere; all arithmetic is XOR. acc is exactly 2N-1 bits and no step writes outside it.

Test Plan:
- Reset: assert rst asynchronously mid-MUL (step=2) -> out_valid=0, in_ready=1, p_out=0 immediately; no out_valid pulse follows.
- Basic products:
  - a=1, b=1 -> p_out=1, out_valid rises exactly 4 edges after acceptance.
  - a=0x3, b=0x3 -> p_out=0x5, since (x+1)^2=x^2+1.
- Edge coefficients:
  - a=0x2000000, b=0x2000000 -> p_out=1<<50.
  - a=0x3FFFFFF, b=0x1 -> p_out=0x3FFFFFF.
  - a=0x2, b=0x2 -> p_out=0x4, exercising the step 3 shift.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> p_out stable, in_ready=0, in_valid pulses ignored. Then out_ready=1 -> IDLE next cycle and in_ready=1.
- Back-to-back: 200 random (a,b) pairs with out_ready random 50% -> every p_out matches a bit-serial carry-less reference model; issue interval ≥6 cycles.
- Step wrap: two consecutive operations -> second result independent of first (acc cleared on accept), step=0 at each accept.

Source files
------------

// File: rtl/obs_even_odd_mul_seq_if.sv
// Handshake bundle for the sequential even/odd carry-less multiplier.
// master: operand producer / product consumer; slave: the multiplier.
interface obs_even_odd_mul_seq_if #(
    parameter int unsigned N = 26
);
    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   a_in;
    logic [N-1:0]   b_in;
    logic           out_valid;
    logic           out_ready;
    logic [2*N-2:0] p_out;
    logic           busy;

    modport master (
        output in_valid, a_in, b_in, out_ready,
        input  in_ready, out_valid, p_out, busy
    );

    modport slave (
        input  in_valid, a_in, b_in, out_ready,
        output in_ready, out_valid, p_out, busy
    );
endinterface

// File: rtl/obs_even_odd_mul_seq.sv
// Sequential GF(2)[x] multiplier using even/odd coefficient split.
// One shared HxH carry-less multiplier is reused over four steps
// (ae*be, ae*bo, ao*be, ao*bo); each sub-product is XORed into an
// interleaved 2N-1 bit accumulator. N must be even.
module obs_even_odd_mul_seq #(
    parameter int unsigned N = 26
) (
    input logic                  clk,
    input logic                  rst,
    obs_even_odd_mul_seq_if.slave bus
);
    localparam int unsigned H  = N / 2;
    localparam int unsigned PW = 2 * H - 1;
    localparam int unsigned AW = 2 * N - 1;

    typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;

    state_e         state_q;
    logic [1:0]     step_q;
    logic [AW-1:0]  acc_q;
    logic [H-1:0]   ae_q, ao_q, be_q, bo_q;
    logic           out_valid_q;
    logic           busy_q;

    logic [H-1:0]   ae_d, ao_d, be_d, bo_d;
    logic [H-1:0]   sel_a, sel_b;
    logic [PW-1:0]  prod;
    logic [AW-1:0]  acc_d;

    // Split incoming operands into even- and odd-indexed coefficients.
    always_comb begin
        ae_d = '0;
        ao_d = '0;
        be_d = '0;
        bo_d = '0;
        for (int i = 0; i < int'(H); i++) begin
            ae_d[i] = bus.a_in[2*i];
            ao_d[i] = bus.a_in[2*i+1];
            be_d[i] = bus.b_in[2*i];
            bo_d[i] = bus.b_in[2*i+1];
        end
    end

    // Shared HxH carry-less sub-multiplier; step[1] picks the A half, step[0] the B half.
    always_comb begin
        sel_a = step_q[1] ? ao_q : ae_q;
        sel_b = step_q[0] ? bo_q : be_q;
        prod  = '0;
        for (int j = 0; j < int'(H); j++) begin
            for (int l = 0; l < int'(H); l++) begin
                prod[j+l] = prod[j+l] ^ (sel_a[j] & sel_b[l]);
            end
        end
    end

    // Scatter the sub-product into the accumulator by the step's parity/offset.
    always_comb begin
        acc_d = acc_q;
        for (int i = 0; i < int'(PW); i++) begin
            case (step_q)
                2'd0:    acc_d[2*i]   = acc_d[2*i]   ^ prod[i];
                2'd1:    acc_d[2*i+1] = acc_d[2*i+1] ^ prod[i];
                2'd2:    acc_d[2*i+1] = acc_d[2*i+1] ^ prod[i];
                default: acc_d[2*i+2] = acc_d[2*i+2] ^ prod[i];
            endcase
        end
    end

    // Control FSM with registered outputs; reset aborts any computation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            step_q      <= 2'd0;
            acc_q       <= '0;
            ae_q        <= '0;
            ao_q        <= '0;
            be_q        <= '0;
            bo_q        <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.in_valid) begin
                        ae_q    <= ae_d;
                        ao_q    <= ao_d;
                        be_q    <= be_d;
                        bo_q    <= bo_d;
                        acc_q   <= '0;
                        step_q  <= 2'd0;
                        busy_q  <= 1'b1;
                        state_q <= StMul;
                    end
                end
                StMul: begin
                    acc_q  <= acc_d;
                    step_q <= step_q + 2'd1;
                    if (step_q == 2'd3) begin
                        out_valid_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= StDone;
                    end
                end
                StDone: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= StIdle;
                end
            endcase
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = out_valid_q;
    assign bus.p_out     = acc_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_obs_even_odd_mul_seq.sv
// Bench for obs_even_odd_mul_seq: directed vectors, reset abort,
// backpressure, and random operations against a bit-serial clmul model.
module tb_obs_even_odd_mul_seq;
    localparam int N = 26;
    localparam int W = 2 * N - 1;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    obs_even_odd_mul_seq_if #(.N(N)) bus ();

    obs_even_odd_mul_seq #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [W-1:0] p;
    } vec_t;

    vec_t   vecs[6];
    int     n_checks = 0;
    int     n_fail   = 0;
    time    last_accept = 0;
    bit     have_accept = 0;

    // Bit-serial carry-less product: XOR of shifted copies of a.
    function automatic logic [W-1:0] clmul_ref(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [W-1:0] p;
        p = '0;
        for (int i = 0; i < N; i++) begin
            if (b[i]) p = p ^ (W'(a) << i);
        end
        return p;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Wait for in_ready, present operands for one accepting edge, then scramble inputs.
    task automatic start_op(input logic [N-1:0] a, input logic [N-1:0] b);
        int t;
        t = 0;
        @(negedge clk);
        while (!bus.in_ready && t < 30) begin
            @(negedge clk);
            t++;
        end
        check("in_ready_before_accept", 64'(bus.in_ready), 64'd1);
        bus.in_valid = 1'b1;
        bus.a_in     = a;
        bus.b_in     = b;
        @(posedge clk);
        if (have_accept) begin
            check("issue_interval_ge6", 64'(($time - last_accept) >= 60), 64'd1);
        end
        last_accept = $time;
        have_accept = 1;
        #1;
        bus.in_valid = 1'b0;
        bus.a_in     = N'($urandom);
        bus.b_in     = N'($urandom);
    endtask

    // Count edges after acceptance until out_valid; returns product and edge count.
    task automatic wait_result(output logic [W-1:0] p, output int edges);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.out_valid && n < 20) begin
            if (n == 0) check("busy_in_mul", 64'(bus.busy), 64'd1);
            @(negedge clk);
            n++;
        end
        check("out_valid_seen", 64'(bus.out_valid), 64'd1);
        p     = bus.p_out;
        edges = n;
    endtask

    // Drain the product with optional random backpressure; called at a negedge with out_valid=1.
    task automatic finish_op(input bit rand_rdy);
        logic [W-1:0] held;
        int           t;
        held = bus.p_out;
        t    = 0;
        forever begin
            bus.out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            if (t > 40) bus.out_ready = 1'b1;
            @(posedge clk);
            if (bus.out_ready) break;
            @(negedge clk);
            t++;
            check("valid_held_under_bp", 64'(bus.out_valid), 64'd1);
            check("p_stable_under_bp", 64'(bus.p_out), 64'(held));
        end
        #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        check("out_valid_drop", 64'(bus.out_valid), 64'd0);
        check("in_ready_after_done", 64'(bus.in_ready), 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] p;
        logic [W-1:0] held;
        logic [N-1:0] ra, rb;
        int           edges;
        int           pulses;

        vecs[0] = '{a: 26'h1,       b: 26'h1,       p: 51'h1};
        vecs[1] = '{a: 26'h3,       b: 26'h3,       p: 51'h5};
        vecs[2] = '{a: 26'h2000000, b: 26'h2000000, p: 51'h4_0000_0000_0000};
        vecs[3] = '{a: 26'h3FFFFFF, b: 26'h1,       p: 51'h3FFFFFF};
        vecs[4] = '{a: 26'h2,       b: 26'h2,       p: 51'h4};
        vecs[5] = '{a: 26'h5,       b: 26'h3,       p: 51'hF};

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a_in      = '0;
        bus.b_in      = '0;
        bus.out_ready = 1'b0;
        #12;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_p_out", 64'(bus.p_out), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed table.
        foreach (vecs[k]) begin
            start_op(vecs[k].a, vecs[k].b);
            wait_result(p, edges);
            check("vec_latency", 64'(edges), 64'd4);
            check($sformatf("vec%0d_product", k), 64'(p), 64'(vecs[k].p));
            finish_op(1'b0);
        end

        // Reset while step=2: immediate abort, no later out_valid.
        start_op(26'h3FFFFFF, 26'h2AAAAAA);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_out_valid", 64'(bus.out_valid), 64'd0);
        check("abort_in_ready", 64'(bus.in_ready), 64'd1);
        check("abort_p_out", 64'(bus.p_out), 64'd0);
        check("abort_busy", 64'(bus.busy), 64'd0);
        #2;
        rst = 1'b0;
        pulses = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.out_valid) pulses++;
        end
        check("abort_no_valid_pulse", 64'(pulses), 64'd0);
        have_accept = 0;

        // Backpressure: 10 stalled cycles with ignored in_valid pulses.
        ra = 26'h1234567;
        rb = 26'h0ABCDEF;
        start_op(ra, rb);
        wait_result(p, edges);
        check("bp_product", 64'(p), 64'(clmul_ref(ra, rb)));
        held = bus.p_out;
        for (int c = 0; c < 10; c++) begin
            bus.in_valid = 1'(c & 1);
            bus.a_in     = N'($urandom);
            bus.b_in     = N'($urandom);
            @(negedge clk);
            check("bp_p_stable", 64'(bus.p_out), 64'(held));
            check("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
            check("bp_valid_high", 64'(bus.out_valid), 64'd1);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        check("bp_release_in_ready", 64'(bus.in_ready), 64'd1);
        check("bp_release_valid_low", 64'(bus.out_valid), 64'd0);
        check("bp_hold_last_result", 64'(bus.p_out), 64'(held));

        // Consecutive ops: second result independent of the first.
        start_op(26'h3FFFFFF, 26'h3FFFFFF);
        wait_result(p, edges);
        check("wrap_first", 64'(p), 64'(clmul_ref(26'h3FFFFFF, 26'h3FFFFFF)));
        finish_op(1'b0);
        start_op(26'h1, 26'h1);
        wait_result(p, edges);
        check("wrap_latency", 64'(edges), 64'd4);
        check("wrap_second", 64'(p), 64'd1);
        finish_op(1'b0);

        // Random back-to-back operations with random consumer readiness.
        for (int r = 0; r < 200; r++) begin
            ra = N'($urandom);
            rb = N'($urandom);
            start_op(ra, rb);
            wait_result(p, edges);
            check("rand_latency", 64'(edges), 64'd4);
            check($sformatf("rand%0d_product", r), 64'(p), 64'(clmul_ref(ra, rb)));
            finish_op(1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
